// File: rtl/jtframe_db15_tx.sv
// Responder end of the SNAC DB15 serial joystick link: captures two players on load and shifts them out.
// Define JTFRAME_DB15_CHK_EN to add the short-frame protocol checker and its short_frame output.
module jtframe_db15_tx #(
    parameter int BITS = 12,
    parameter int SYNC = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BITS-1:0]               joy1,
    input  logic [BITS-1:0]               joy2,
    input  logic                          joy_clk,
    input  logic                          joy_load,
    output logic                          joy_data,
    output logic                          frame_done,
    output logic [$clog2(2*BITS+1)-1:0]   bit_cnt,
`ifdef JTFRAME_DB15_CHK_EN
    output logic                          short_frame,
`endif
    output logic [1:0]                    dbg_state
);

    localparam int FW = 2 * BITS;
    localparam int CW = $clog2(2 * BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(FW);

    // Encoding is visible on dbg_state: 0 IDLE, 1 LOAD, 2 SHIFT, 3 DONE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [SYNC-1:0]   clk_sync_q;
    logic [SYNC-1:0]   load_sync_q;
    logic              clk_prev_q;
    logic [FW-1:0]     sr_q;
    logic [CW-1:0]     cnt_q;
    logic              frame_done_q;
`ifdef JTFRAME_DB15_CHK_EN
    logic              short_frame_q;
`endif

    logic              clk_rise_d;
    logic              load_act_d;
    logic [FW-1:0]     frame_word_d;
    logic [FW-1:0]     sr_shift_d;

    always_comb begin
        clk_rise_d   = clk_sync_q[SYNC-1] & ~clk_prev_q;
        load_act_d   = ~load_sync_q[SYNC-1];
        frame_word_d = {~joy2, ~joy1};
        sr_shift_d   = {1'b1, sr_q[FW-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q    <= '0;
            load_sync_q   <= '1;
            clk_prev_q    <= 1'b0;
            state_q       <= ST_IDLE;
            sr_q          <= '1;
            cnt_q         <= '0;
            frame_done_q  <= 1'b0;
`ifdef JTFRAME_DB15_CHK_EN
            short_frame_q <= 1'b0;
`endif
        end else begin
            clk_sync_q   <= {clk_sync_q[SYNC-2:0], joy_clk};
            load_sync_q  <= {load_sync_q[SYNC-2:0], joy_load};
            clk_prev_q   <= clk_sync_q[SYNC-1];
            frame_done_q <= 1'b0;
`ifdef JTFRAME_DB15_CHK_EN
            short_frame_q <= 1'b0;
`endif
            // Load has priority over everything, including a coincident clock rise.
            if (load_act_d) begin
`ifdef JTFRAME_DB15_CHK_EN
                if (state_q == ST_SHIFT && cnt_q != '0 && cnt_q != FULL) begin
                    short_frame_q <= 1'b1;
`ifdef SIMULATION
                    $display("jtframe_db15_tx: warning, load arrived after %0d bits", cnt_q);
`endif
                end
`endif
                state_q <= ST_LOAD;
                sr_q    <= frame_word_d;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_LOAD: state_q <= ST_SHIFT;
                    ST_SHIFT: begin
                        if (cnt_q == FULL) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end else if (clk_rise_d) begin
                            sr_q  <= sr_shift_d;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_DONE: begin
                        if (clk_rise_d) sr_q <= sr_shift_d;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign joy_data   = sr_q[0];
    assign frame_done = frame_done_q;
    assign bit_cnt    = cnt_q;
    assign dbg_state  = state_q;
`ifdef JTFRAME_DB15_CHK_EN
    assign short_frame = short_frame_q;
`endif

endmodule

// File: tb/tb_jtframe_db15_tx.sv
// Bench for jtframe_db15_tx: random joystick frames checked against a pressed-button list model.
module tb_jtframe_db15_tx;

    localparam int BITS = 12;
    localparam int SYNC = 2;
    localparam int FW   = 2 * BITS;
    localparam int CW   = $clog2(FW + 1);
    localparam int HALF = 8;
    localparam logic [1:0] ST_LOAD = 2'd1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BITS-1:0] joy1 = '0;
    logic [BITS-1:0] joy2 = '0;
    logic            joy_clk = 1'b0;
    logic            joy_load = 1'b1;
    logic            joy_data;
    logic            frame_done;
    logic [CW-1:0]   bit_cnt;
    logic [1:0]      dbg_state;
`ifdef JTFRAME_DB15_CHK_EN
    logic            short_frame;
`endif

    jtframe_db15_tx #(.BITS(BITS), .SYNC(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .joy1       (joy1),
        .joy2       (joy2),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .bit_cnt    (bit_cnt),
`ifdef JTFRAME_DB15_CHK_EN
        .short_frame(short_frame),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            short_cnt = 0;
    logic [CW-1:0] done_bc = '0;
    logic [0:0]    exp_q[$];

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            done_bc = bit_cnt;
        end
`ifdef JTFRAME_DB15_CHK_EN
        if (short_frame) short_cnt++;
`endif
    end

    // Expected serial stream: player 1 buttons in order, then player 2; pressed reads as 0.
    function automatic void build_frame(input logic [BITS-1:0] p1, input logic [BITS-1:0] p2);
        logic pressed;
        exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < BITS; b++) begin
                pressed = (p == 0) ? p1[b] : p2[b];
                exp_q.push_back(pressed ? 1'b0 : 1'b1);
            end
        end
    endfunction

    // After n link clock rises the line shows stream bit n; beyond the frame it idles high.
    function automatic logic exp_bit(input int n);
        logic [0:0] v;
        v = 1'b1;
        if (n < exp_q.size()) v = exp_q[n];
        return v[0];
    endfunction

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int n);
        joy_load = 1'b0;
        tick(n);
        joy_load = 1'b1;
        tick(SYNC + 3);
    endtask

    task automatic rise_hi();
        joy_clk = 1'b1;
        tick(HALF);
    endtask

    task automatic fall_lo();
        joy_clk = 1'b0;
        tick(HALF);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int k;
        rst = 1'b1;
        joy_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (joy_data !== 1'b1) begin
                errors++; $display("FAIL reset joy_data: got %b expected 1", joy_data);
            end
            checks++;
            if (bit_cnt !== '0) begin
                errors++; $display("FAIL reset bit_cnt: got %0d expected 0", bit_cnt);
            end
            checks++;
            if (frame_done !== 1'b0) begin
                errors++; $display("FAIL reset frame_done: got %b expected 0", frame_done);
            end
        end
        rst = 1'b0;
        // k counts edges from the first edge that samples rst low; that edge is the release.
        k = 0;
        while (dbg_state !== ST_LOAD && k < 20) begin
            tick(1);
            k++;
        end
        checks++;
        if (k - 1 !== SYNC) begin
            errors++; $display("FAIL reset load latency: got %0d expected %0d", k - 1, SYNC);
        end
        joy_load = 1'b1;
        tick(SYNC + 3);
    endtask

    task automatic test_frame(input logic [BITS-1:0] p1, input logic [BITS-1:0] p2);
        joy1 = p1;
        joy2 = p2;
        build_frame(p1, p2);
        do_load(10);
        done_cnt = 0;
        checks++;
        if (joy_data !== exp_bit(0)) begin
            errors++; $display("FAIL frame bit 0: got %b expected %b", joy_data, exp_bit(0));
        end
        for (int n = 1; n <= FW; n++) begin
            rise_hi();
            checks++;
            if (joy_data !== exp_bit(n)) begin
                errors++; $display("FAIL frame after rise %0d: got %b expected %b", n, joy_data, exp_bit(n));
            end
            fall_lo();
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL frame_done pulses: got %0d expected 1", done_cnt);
        end
        checks++;
        if (done_bc !== CW'(FW)) begin
            errors++; $display("FAIL frame_done bit_cnt: got %0d expected %0d", done_bc, FW);
        end
        checks++;
        if (bit_cnt !== CW'(FW)) begin
            errors++; $display("FAIL frame end bit_cnt: got %0d expected %0d", bit_cnt, FW);
        end
    endtask

    task automatic test_overrun();
        for (int n = 0; n < 5; n++) begin
            rise_hi();
            checks++;
            if (joy_data !== 1'b1) begin
                errors++; $display("FAIL overrun joy_data rise %0d: got %b expected 1", n, joy_data);
            end
            checks++;
            if (bit_cnt !== CW'(FW)) begin
                errors++; $display("FAIL overrun bit_cnt rise %0d: got %0d expected %0d", n, bit_cnt, FW);
            end
            fall_lo();
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL overrun frame_done pulses: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_load_during_shift();
        int s0;
        joy1 = BITS'($urandom_range(0, (1 << BITS) - 1));
        joy2 = BITS'($urandom_range(0, (1 << BITS) - 1));
        build_frame(joy1, joy2);
        do_load(8);
        for (int n = 1; n <= 7; n++) begin
            rise_hi();
            checks++;
            if (joy_data !== exp_bit(n)) begin
                errors++; $display("FAIL midload after rise %0d: got %b expected %b", n, joy_data, exp_bit(n));
            end
            fall_lo();
        end
        s0 = short_cnt;
        joy_load = 1'b0;
        tick(SYNC + 2);
        checks++;
        if (bit_cnt !== '0) begin
            errors++; $display("FAIL midload bit_cnt: got %0d expected 0", bit_cnt);
        end
        checks++;
        if (joy_data !== ~joy1[0]) begin
            errors++; $display("FAIL midload joy_data: got %b expected %b", joy_data, ~joy1[0]);
        end
        checks++;
        if (dbg_state !== ST_LOAD) begin
            errors++; $display("FAIL midload state: got %0d expected %0d", dbg_state, ST_LOAD);
        end
        joy_load = 1'b1;
        tick(SYNC + 3);
`ifdef JTFRAME_DB15_CHK_EN
        checks++;
        if (short_cnt - s0 !== 1) begin
            errors++; $display("FAIL short_frame pulses: got %0d expected 1", short_cnt - s0);
        end
`endif
    endtask

    task automatic test_simultaneous();
        joy1 = BITS'($urandom_range(0, (1 << BITS) - 1));
        joy2 = BITS'($urandom_range(0, (1 << BITS) - 1));
        build_frame(joy1, joy2);
        do_load(6);
        for (int n = 0; n < 3; n++) begin
            rise_hi();
            fall_lo();
        end
        joy_clk = 1'b1;
        joy_load = 1'b0;
        tick(6);
        joy_load = 1'b1;
        tick(SYNC + 3);
        checks++;
        if (bit_cnt !== '0) begin
            errors++; $display("FAIL simult bit_cnt: got %0d expected 0", bit_cnt);
        end
        checks++;
        if (joy_data !== exp_bit(0)) begin
            errors++; $display("FAIL simult bit 0: got %b expected %b", joy_data, exp_bit(0));
        end
        fall_lo();
        rise_hi();
        checks++;
        if (joy_data !== exp_bit(1)) begin
            errors++; $display("FAIL simult bit 1: got %b expected %b", joy_data, exp_bit(1));
        end
        checks++;
        if (bit_cnt !== CW'(1)) begin
            errors++; $display("FAIL simult bit_cnt after rise: got %0d expected 1", bit_cnt);
        end
        fall_lo();
    endtask

    task automatic test_load_track();
        logic frozen;
        joy1 = BITS'($urandom_range(0, (1 << BITS) - 1));
        joy2 = BITS'($urandom_range(0, (1 << BITS) - 1));
        joy_load = 1'b0;
        tick(SYNC + 2);
        for (int i = 0; i < 4; i++) begin
            joy1[4] = ~joy1[4];
            tick(1);
            checks++;
            if (dut.sr_q[4] !== ~joy1[4]) begin
                errors++; $display("FAIL track sr[4] step %0d: got %b expected %b", i, dut.sr_q[4], ~joy1[4]);
            end
        end
        frozen = joy1[4];
        build_frame(joy1, joy2);
        joy_load = 1'b1;
        tick(SYNC + 3);
        joy1[4] = ~joy1[4];
        for (int n = 1; n <= 4; n++) begin
            rise_hi();
            checks++;
            if (joy_data !== exp_bit(n)) begin
                errors++; $display("FAIL track after rise %0d: got %b expected %b", n, joy_data, exp_bit(n));
            end
            fall_lo();
        end
        checks++;
        if (joy_data !== ~frozen) begin
            errors++; $display("FAIL track frozen bit 4: got %b expected %b", joy_data, ~frozen);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_frame(12'h001, 12'h800);
        test_overrun();
        for (int r = 0; r < 3; r++) begin
            test_frame(BITS'($urandom_range(0, (1 << BITS) - 1)), BITS'($urandom_range(0, (1 << BITS) - 1)));
        end
        test_load_during_shift();
        test_simultaneous();
        test_load_track();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
